// File: rtl/wb_stage.sv
// Purpose: RV32 writeback stage; load extraction/extension, register file write, retire/exception pulses.
// Latency: non-load 1 cycle to write; load 1 cycle after dmem_rvalid_i (min 2 cycles handshake-to-accept).
// Backpressure: mem_ready_o=1 only in IDLE; deasserted while a load waits for dmem_rvalid_i.
//
// Ports: clk_i/rst_ni (async active-low); mem_* from MEM stage (valid/ready);
//        dmem_rvalid_i/dmem_rdata_i load return; write_reg_addr/write_reg_data/wen to the
//        register file; retire_o/load_exc_o single-cycle pulses; instret_o retire count.
// Option: define WB_INSTRET_EN to build the 64-bit instret counter (otherwise tied to 0).
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_reg_write_i,
    input  logic            mem_is_load_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [1:0]      mem_addr_lo_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [4:0]      write_reg_addr,
    output logic [XLEN-1:0] write_reg_data,
    output logic            wen,
    output logic            retire_o,
    output logic            load_exc_o,
    output logic [63:0]     instret_o
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t          state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            wen_q, wen_d;
    logic            retire_q, retire_d;
    logic            exc_q, exc_d;

    logic            load_bad;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [XLEN-1:0] load_val;

    assign mem_ready_o = (state_q == IDLE);

    // Illegal width codes (011, 110, 111) and misaligned halfword/word accesses
    // are rejected at the handshake so no memory response is ever awaited.
    always_comb begin
        load_bad = 1'b0;
        unique case (mem_funct3_i)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = mem_addr_lo_i[0];
            3'b010:         load_bad = (mem_addr_lo_i != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    end

    // Extraction uses the offset and width captured at the handshake.
    always_comb begin
        sel_byte = 8'h00;
        unique case (addr_lo_q)
            2'd0: sel_byte = dmem_rdata_i[7:0];
            2'd1: sel_byte = dmem_rdata_i[15:8];
            2'd2: sel_byte = dmem_rdata_i[23:16];
            2'd3: sel_byte = dmem_rdata_i[31:24];
        endcase
        sel_half = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_val = dmem_rdata_i;
        unique case (funct3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_val = {24'h000000, sel_byte};
            3'b101:  load_val = {16'h0000, sel_half};
            default: load_val = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        reg_write_d = reg_write_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b0;
        retire_d    = 1'b0;
        exc_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    if (!mem_is_load_i) begin
                        waddr_d  = mem_rd_i;
                        wdata_d  = mem_result_i;
                        wen_d    = mem_reg_write_i && (mem_rd_i != 5'd0);
                        retire_d = 1'b1;
                    end else if (load_bad) begin
                        exc_d = 1'b1;
                    end else begin
                        rd_d        = mem_rd_i;
                        funct3_d    = mem_funct3_i;
                        addr_lo_d   = mem_addr_lo_i;
                        reg_write_d = mem_reg_write_i;
                        state_d     = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    waddr_d  = rd_q;
                    wdata_d  = load_val;
                    wen_d    = reg_write_q && (rd_q != 5'd0);
                    retire_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            reg_write_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            retire_q    <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            retire_q    <= retire_d;
            exc_q       <= exc_d;
        end
    end

    assign write_reg_addr = waddr_q;
    assign write_reg_data = wdata_q;
    assign wen            = wen_q;
    assign retire_o       = retire_q;
    assign load_exc_o     = exc_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Counts the registered retire pulse, so the count trails retire_o by one cycle.
    always_comb begin
        instret_d = instret_q;
        if (retire_q) instret_d = instret_q + 64'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) instret_q <= '0;
        else         instret_q <= instret_d;
    end

    assign instret_o = instret_q;
`else
    assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic        mem_reg_write_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic [1:0]  mem_addr_lo_i;
    logic [31:0] mem_result_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_reg_data;
    logic        wen;
    logic        retire_o;
    logic        load_exc_o;
    logic [63:0] instret_o;

    int total = 0;
    int bad   = 0;

    wb_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
        .mem_is_load_i(mem_is_load_i), .mem_funct3_i(mem_funct3_i),
        .mem_addr_lo_i(mem_addr_lo_i), .mem_result_i(mem_result_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .wen(wen), .retire_o(retire_o), .load_exc_o(load_exc_o),
        .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic nonload(input logic [4:0] rd, input logic [31:0] res, input logic rw);
        mem_valid_i = 1'b1; mem_is_load_i = 1'b0; mem_rd_i = rd;
        mem_result_i = res; mem_reg_write_i = rw;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        mem_valid_i = 1'b1; mem_is_load_i = 1'b1; mem_rd_i = rd;
        mem_funct3_i = f3; mem_addr_lo_i = lo; mem_reg_write_i = 1'b1;
    endtask

    task automatic idle_in();
        mem_valid_i = 1'b0; mem_is_load_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; mem_valid_i = 1'b0; mem_rd_i = '0; mem_reg_write_i = 1'b0;
        mem_is_load_i = 1'b0; mem_funct3_i = '0; mem_addr_lo_i = '0;
        mem_result_i = '0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        step(); step();
        chk("rst_wen", wen, 0);
        chk("rst_retire", retire_o, 0);
        chk("rst_exc", load_exc_o, 0);
        chk("rst_waddr", write_reg_addr, 0);
        chk("rst_wdata", write_reg_data, 0);
        chk("rst_instret", instret_o, 0);
        chk("rst_ready", mem_ready_o, 1);
        rst_ni = 1'b1;

        // Non-load, then three back-to-back
        nonload(5'd5, 32'hDEADBEEF, 1'b1); step();
        chk("nl_wen", wen, 1);
        chk("nl_addr", write_reg_addr, 5);
        chk("nl_data", write_reg_data, 32'hDEADBEEF);
        chk("nl_retire", retire_o, 1);
        nonload(5'd1, 32'h11111111, 1'b1); step();
        chk("b2b1_data", {write_reg_addr, write_reg_data, wen, retire_o}, {5'd1, 32'h11111111, 2'b11});
        nonload(5'd2, 32'h22222222, 1'b1); step();
        chk("b2b2_data", {write_reg_addr, write_reg_data, wen, retire_o}, {5'd2, 32'h22222222, 2'b11});
        nonload(5'd3, 32'h33333333, 1'b1); step();
        chk("b2b3_data", {write_reg_addr, write_reg_data, wen, retire_o}, {5'd3, 32'h33333333, 2'b11});
        idle_in(); step();
        chk("idle_pulse_off", {wen, retire_o}, 2'b00);
        chk("idle_hold_data", write_reg_data, 32'h33333333);

        // LB addr_lo=3, data two cycles later
        load(5'd6, 3'b000, 2'd3); step();
        chk("lb_wait_ready", mem_ready_o, 0);
        chk("lb_no_pulse", {wen, retire_o, load_exc_o}, 3'b000);
        idle_in(); step();
        chk("lb_wait_ready2", mem_ready_o, 0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80123456; step();
        chk("lb_data", write_reg_data, 32'hFFFFFF80);
        chk("lb_wen_retire", {write_reg_addr, wen, retire_o}, {5'd6, 2'b11});
        chk("lb_ready_back", mem_ready_o, 1);
        dmem_rvalid_i = 1'b0;

        // LBU same pattern
        load(5'd7, 3'b100, 2'd3); step();
        idle_in(); step();
        dmem_rvalid_i = 1'b1; step();
        chk("lbu_data", write_reg_data, 32'h00000080);
        dmem_rvalid_i = 1'b0;

        // LH addr 2 / LHU addr 0 with minimum latency
        dmem_rdata_i = 32'h9ABC1234;
        load(5'd8, 3'b001, 2'd2); step();
        idle_in(); dmem_rvalid_i = 1'b1; step();
        chk("lh_data", write_reg_data, 32'hFFFF9ABC);
        load(5'd9, 3'b101, 2'd0); step();
        chk("lhu_noaccept_retire", retire_o, 0);
        idle_in(); dmem_rvalid_i = 1'b1; step();
        chk("lhu_data", write_reg_data, 32'h00001234);
        chk("lhu_addr", write_reg_addr, 9);
        idle_in();

        // Misaligned LW and illegal funct3
        load(5'd10, 3'b010, 2'd1); step();
        chk("lw_mis_exc", {load_exc_o, wen, retire_o, mem_ready_o}, 4'b1001);
        load(5'd10, 3'b011, 2'd0); step();
        chk("f3_011_exc", {load_exc_o, wen, retire_o, mem_ready_o}, 4'b1001);
        load(5'd10, 3'b111, 2'd0); step();
        chk("f3_111_exc", load_exc_o, 1);
        idle_in(); step();
        chk("exc_off", load_exc_o, 0);
        chk("exc_hold_data", write_reg_data, 32'h00001234);

        // Spurious rvalid in IDLE
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D; step();
        chk("spur_no_write", {wen, retire_o}, 2'b00);
        chk("spur_data_hold", write_reg_data, 32'h00001234);
        dmem_rvalid_i = 1'b0;

        // rd=0 retires but no write
        nonload(5'd0, 32'h12345678, 1'b1); step();
        chk("rd0", {wen, retire_o}, 2'b01);
        // reg_write=0 also no write
        nonload(5'd4, 32'h0, 1'b0); step();
        chk("rw0", {wen, retire_o}, 2'b01);

        // Reset mid-WAIT_LOAD
        load(5'd11, 3'b010, 2'd0); step();
        idle_in();
        chk("pre_rst_wait", mem_ready_o, 0);
        #2 rst_ni = 1'b0; #1;
        chk("mid_rst_out", {write_reg_addr, write_reg_data, wen, retire_o, load_exc_o}, 40'd0);
        chk("mid_rst_instret", instret_o, 0);
        chk("mid_rst_ready", mem_ready_o, 1);
        step(); rst_ni = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF; step();
        chk("post_rst_rvalid", {wen, retire_o, write_reg_data}, 34'd0);
        dmem_rvalid_i = 1'b0;

        // Ten retires and one exception
        for (int i = 1; i <= 10; i++) begin
            nonload(i[4:0], i, 1'b1); step();
        end
        load(5'd12, 3'b110, 2'd0); step();
        chk("cnt_exc", load_exc_o, 1);
        idle_in(); step(); step();
`ifdef WB_INSTRET_EN
        chk("instret", instret_o, 64'd10);
`else
        chk("instret", instret_o, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
